// File: rtl/pci_arbiter.sv
// pci_arbiter: three-device PCI bus arbiter with a dead cycle between grants
// and an idle-grant timeout.
// Build option: define PCI_ARB_ROUND_ROBIN_EN for round-robin selection with a
// last-winner pointer; without it, selection is fixed priority A > B > C.
module pci_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [2:0] Req,
  input  logic       Frame,
  input  logic       IRDY,
  output logic [2:0] GNT,
  output logic [1:0] Bus_Owner,
  output logic       Bus_Busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_BUSY    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'b11;
  localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [4:0] cnt;
  logic [4:0] cnt_nx;
  logic [1:0] own_nx;
  logic [1:0] winner;
  logic       bus_idle;

  // Active-low grant vector for an encoded owner; "none" releases every line.
  function automatic logic [2:0] gnt_of(input logic [1:0] own);
    case (own)
      2'd0:    gnt_of = 3'b110;
      2'd1:    gnt_of = 3'b101;
      2'd2:    gnt_of = 3'b011;
      default: gnt_of = 3'b111;
    endcase
  endfunction

  assign bus_idle = Frame & IRDY;

`ifdef PCI_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;
  logic [1:0] ptr_nx;

  // Cyclic successor in A -> B -> C -> A order.
  function automatic logic [1:0] succ(input logic [1:0] p);
    case (p)
      2'd0:    succ = 2'd1;
      2'd1:    succ = 2'd2;
      default: succ = 2'd0;
    endcase
  endfunction

  // First requester strictly after the last winner; the last winner itself comes last.
  function automatic logic [1:0] pick(input logic [2:0] req_n, input logic [1:0] p);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] c3;
    c1 = succ(p);
    c2 = succ(c1);
    c3 = succ(c2);
    if (!req_n[c1])      pick = c1;
    else if (!req_n[c2]) pick = c2;
    else if (!req_n[c3]) pick = c3;
    else                 pick = OWN_NONE;
  endfunction

  assign winner = pick(Req, ptr);
`else
  // Fixed priority: A beats B beats C.
  function automatic logic [1:0] pick(input logic [2:0] req_n);
    if (!req_n[0])      pick = 2'd0;
    else if (!req_n[1]) pick = 2'd1;
    else if (!req_n[2]) pick = 2'd2;
    else                pick = OWN_NONE;
  endfunction

  assign winner = pick(Req);
`endif

  // Next-state, idle counter, owner and (optionally) last-winner pointer.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    own_nx   = Bus_Owner;
`ifdef PCI_ARB_ROUND_ROBIN_EN
    ptr_nx   = ptr;
`endif
    case (state)
      ST_IDLE, ST_RELEASE: begin
        // Frame is ignored here: nobody holds a grant.
        if (Req != 3'b111) begin
          state_nx = ST_GRANT;
          cnt_nx   = 5'd0;
          own_nx   = winner;
        end else begin
          state_nx = ST_IDLE;
          own_nx   = OWN_NONE;
        end
      end
      ST_GRANT: begin
        if (!Frame) begin
          state_nx = ST_BUSY;
`ifdef PCI_ARB_ROUND_ROBIN_EN
          ptr_nx   = Bus_Owner;
`endif
        end else if (cnt == CNT_LAST) begin
          // Timeout takes precedence over a simultaneous request withdrawal,
          // and demotes the idle owner so others get the next turn.
          state_nx = ST_RELEASE;
          own_nx   = OWN_NONE;
`ifdef PCI_ARB_ROUND_ROBIN_EN
          ptr_nx   = Bus_Owner;
`endif
        end else if (Req[Bus_Owner]) begin
          state_nx = ST_RELEASE;
          own_nx   = OWN_NONE;
        end else begin
          cnt_nx   = cnt + 5'd1;
        end
      end
      ST_BUSY: begin
        // Grant is held regardless of Req until the bus goes idle.
        if (bus_idle) begin
          state_nx = ST_RELEASE;
          own_nx   = OWN_NONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        own_nx   = OWN_NONE;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      cnt       <= 5'd0;
      Bus_Owner <= OWN_NONE;
      GNT       <= 3'b111;
      Bus_Busy  <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Bus_Owner <= own_nx;
      GNT       <= gnt_of(own_nx);
      Bus_Busy  <= (state_nx == ST_BUSY);
    end
  end

`ifdef PCI_ARB_ROUND_ROBIN_EN
  // Last-winner pointer; reset value 2 makes device A the first winner.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) ptr <= 2'd2;
    else     ptr <= ptr_nx;
  end
`endif

endmodule
